// File: rtl/ctrl_sequencer_pkg.sv
// ----------------------------------------------------------------------------
// ctrl_sequencer_pkg
// Shared definitions for the multi-cycle control sequencer:
//   ctrl_state_t   - sequencer FSM states
//   op_mne         - 4-bit ALU operation mnemonics (also drives AluOp)
//   instr_class_t  - coarse instruction class produced by the field decoder
//   OP_*           - non-ALU opcode constants (IR[8:5])
//   classify()     - opcode -> instruction class
// ----------------------------------------------------------------------------
package ctrl_sequencer_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5,
        HALT   = 3'd6
    } ctrl_state_t;

    // Opcodes 0x0..0x9 are passed straight through to the ALU.
    typedef enum logic [3:0] {
        ALU_ADD = 4'h0,
        ALU_SUB = 4'h1,
        ALU_AND = 4'h2,
        ALU_OR  = 4'h3,
        ALU_XOR = 4'h4,
        ALU_SHL = 4'h5,
        ALU_SHR = 4'h6,
        ALU_SLT = 4'h7,
        ALU_SEQ = 4'h8,
        ALU_MOV = 4'h9
    } op_mne;

    typedef enum logic [2:0] {
        CLS_ALU = 3'd0,
        CLS_LDR = 3'd1,
        CLS_STR = 3'd2,
        CLS_BRC = 3'd3,
        CLS_BRU = 3'd4,
        CLS_NOP = 3'd5,
        CLS_HLT = 3'd6
    } instr_class_t;

    localparam logic [3:0] OP_LDR = 4'hA;
    localparam logic [3:0] OP_STR = 4'hB;
    localparam logic [3:0] OP_BRC = 4'hC;
    localparam logic [3:0] OP_BRU = 4'hD;
    localparam logic [3:0] OP_NOP = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    function automatic instr_class_t classify(input logic [3:0] opcode);
        instr_class_t cls;
        case (opcode)
            OP_LDR:  cls = CLS_LDR;
            OP_STR:  cls = CLS_STR;
            OP_BRC:  cls = CLS_BRC;
            OP_BRU:  cls = CLS_BRU;
            OP_NOP:  cls = CLS_NOP;
            OP_HLT:  cls = CLS_HLT;
            default: cls = CLS_ALU;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/ctrl_sequencer_instr_field_decoder.sv
// ----------------------------------------------------------------------------
// instr_field_decoder
// Purely combinational split of the instruction register into its fields.
// Ports:
//   ir          in   IW   instruction register contents
//   iclass      out       instruction class (ALU / LDR / STR / BRC / BRU / NOP / HLT)
//   alu_op      out  4    ALU operation, meaningful only for CLS_ALU
//   reg_addr    out  3    register file address IR[4:2]
//   imm_sel     out  1    immediate select IR[1]
//   branch_idx  out  5    branch LUT index IR[4:0]
// ----------------------------------------------------------------------------
module instr_field_decoder
    import ctrl_sequencer_pkg::*;
#(
    parameter int IW = 9
) (
    input  logic [IW-1:0] ir,
    output instr_class_t  iclass,
    output op_mne         alu_op,
    output logic [2:0]    reg_addr,
    output logic          imm_sel,
    output logic [4:0]    branch_idx
);

    logic [3:0] opcode;

    assign opcode     = ir[IW-1 -: 4];
    assign iclass     = classify(opcode);
    // Only consumed when the class is ALU, where the opcode is a legal op_mne.
    assign alu_op     = op_mne'(opcode);
    assign reg_addr   = ir[4:2];
    assign imm_sel    = ir[1];
    assign branch_idx = ir[4:0];

endmodule

// File: rtl/ctrl_sequencer.sv
// ----------------------------------------------------------------------------
// ctrl_sequencer
// Multi-cycle fetch/decode/execute control unit. Drives the ALU opcode
// interface, consumes the ALU's registered Cond flag for conditional
// branches, and handshakes with data memory.
//
// Build option: define MEM_TIMEOUT_EN to bound the memory wait at MAX_WAIT
// cycles; on expiry the sequencer halts with Fault=1. Without it the MEM
// state waits indefinitely and Fault is tied low.
//
// Ports:
//   Clk          in   1    clock, rising edge
//   Reset        in   1    asynchronous, active-high
//   Start        in   1    pulse; leaves IDLE or HALT
//   InstrIn      in   IW   instruction at current PC
//   Cond         in   1    registered ALU condition flag
//   MemReady     in   1    data memory completion strobe
//   IrLoad       out  1    IR captures InstrIn this cycle
//   AluOp        out  4    ALU operation
//   AluSrcImm    out  1    ALU B operand is immediate
//   RegAddr      out  3    register file address
//   RegWrEn      out  1    register write enable
//   MemToReg     out  1    writeback data from memory
//   MemRdEn      out  1    data memory read request
//   MemWrEn      out  1    data memory write request
//   PcEn         out  1    advance PC, one pulse per retired instruction
//   PcBranch     out  1    with PcEn, load PC from branch LUT
//   BranchIdx    out  5    branch LUT index
//   Done         out  1    halted
//   RetireCount  out  CW   instructions retired since reset
//   Fault        out  1    memory timeout flag
//
// State  | Meaning
// -------+------------------------------------------------------------
// IDLE   | after reset, waiting for Start
// FETCH  | IR captures InstrIn
// DECODE | classify IR, no enables
// EXEC   | ALU op / branch / NOP, retires
// MEM    | hold read or write request until MemReady
// WB     | load writeback from memory, retires
// HALT   | Done=1 until Start
// ----------------------------------------------------------------------------
module ctrl_sequencer
    import ctrl_sequencer_pkg::*;
#(
    parameter int IW       = 9,
    parameter int CW       = 16
`ifdef MEM_TIMEOUT_EN
   ,parameter int MAX_WAIT = 15
`endif
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          Start,
    input  logic [IW-1:0] InstrIn,
    input  logic          Cond,
    input  logic          MemReady,
    output logic          IrLoad,
    output logic [3:0]    AluOp,
    output logic          AluSrcImm,
    output logic [2:0]    RegAddr,
    output logic          RegWrEn,
    output logic          MemToReg,
    output logic          MemRdEn,
    output logic          MemWrEn,
    output logic          PcEn,
    output logic          PcBranch,
    output logic [4:0]    BranchIdx,
    output logic          Done,
    output logic [CW-1:0] RetireCount,
    output logic          Fault
);

    ctrl_state_t   state, next_state;
    logic [IW-1:0] ir;
    logic [CW-1:0] retire_cnt;

    instr_class_t  iclass;
    op_mne         dec_alu_op;
    op_mne         alu_op_sel;
    logic          dec_imm;

    instr_field_decoder #(.IW(IW)) u_decoder (
        .ir         (ir),
        .iclass     (iclass),
        .alu_op     (dec_alu_op),
        .reg_addr   (RegAddr),
        .imm_sel    (dec_imm),
        .branch_idx (BranchIdx)
    );

`ifdef MEM_TIMEOUT_EN
    localparam int WAIT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT + 1) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

    logic [WAIT_W-1:0] wait_cnt;
    logic              timeout;
    logic              fault_q;

    // Fires on the MEM cycle whose missing MemReady makes the count reach MAX_WAIT.
    assign timeout = (state == MEM) && !MemReady && (wait_cnt == WAIT_LAST);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            wait_cnt <= '0;
        end else if (state != MEM) begin
            wait_cnt <= '0;
        end else if (!MemReady) begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            fault_q <= 1'b0;
        end else if (timeout) begin
            fault_q <= 1'b1;
        end else if (Start && (state == IDLE || state == HALT)) begin
            fault_q <= 1'b0;
        end
    end

    assign Fault = fault_q;
`else
    assign Fault = 1'b0;
`endif

    // State register
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (Start) next_state = FETCH;
            FETCH:   next_state = DECODE;
            DECODE: begin
                case (iclass)
                    CLS_LDR, CLS_STR: next_state = MEM;
                    CLS_HLT:          next_state = HALT;
                    default:          next_state = EXEC;
                endcase
            end
            EXEC:    next_state = FETCH;
            MEM: begin
                if (MemReady) begin
                    next_state = (iclass == CLS_LDR) ? WB : FETCH;
                end
`ifdef MEM_TIMEOUT_EN
                else if (timeout) begin
                    next_state = HALT;
                end
`endif
            end
            WB:      next_state = FETCH;
            HALT:    if (Start) next_state = FETCH;
            default: next_state = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        IrLoad     = 1'b0;
        alu_op_sel = ALU_ADD;
        AluSrcImm  = 1'b0;
        RegWrEn    = 1'b0;
        MemToReg   = 1'b0;
        MemRdEn    = 1'b0;
        MemWrEn    = 1'b0;
        PcEn       = 1'b0;
        PcBranch   = 1'b0;
        Done       = 1'b0;
        case (state)
            FETCH: IrLoad = 1'b1;
            EXEC: begin
                case (iclass)
                    CLS_ALU: begin
                        // The only place a non-ADD op reaches the ALU, so
                        // Cond can only change on SLT/SEQ execute cycles.
                        alu_op_sel = dec_alu_op;
                        AluSrcImm  = dec_imm;
                        RegWrEn    = 1'b1;
                        PcEn       = 1'b1;
                    end
                    CLS_BRC: begin
                        PcEn     = 1'b1;
                        PcBranch = Cond;
                    end
                    CLS_BRU: begin
                        PcEn     = 1'b1;
                        PcBranch = 1'b1;
                    end
                    CLS_NOP: PcEn = 1'b1;
                    default: ;
                endcase
            end
            MEM: begin
                if (iclass == CLS_LDR) begin
                    MemRdEn = 1'b1;
                end
                if (iclass == CLS_STR) begin
                    // A store retires on the very cycle memory accepts it.
                    MemWrEn = 1'b1;
                    PcEn    = MemReady;
                end
            end
            WB: begin
                RegWrEn  = 1'b1;
                MemToReg = 1'b1;
                PcEn     = 1'b1;
            end
            HALT: Done = 1'b1;
            default: ;
        endcase
    end

    assign AluOp = alu_op_sel;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            ir <= '0;
        end else if (IrLoad) begin
            ir <= InstrIn;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            retire_cnt <= '0;
        end else if (PcEn) begin
            retire_cnt <= retire_cnt + CW'(1);
        end
    end

    assign RetireCount = retire_cnt;

endmodule

// File: tb/tb_ctrl_sequencer.sv
module tb_ctrl_sequencer;

    localparam int TB_CW       = 4;
    localparam int TB_MAX_WAIT = 15;

    logic             Clk = 1'b0;
    logic             Reset;
    logic             Start;
    logic [8:0]       InstrIn;
    logic             Cond;
    logic             MemReady;
    logic             IrLoad;
    logic [3:0]       AluOp;
    logic             AluSrcImm;
    logic [2:0]       RegAddr;
    logic             RegWrEn;
    logic             MemToReg;
    logic             MemRdEn;
    logic             MemWrEn;
    logic             PcEn;
    logic             PcBranch;
    logic [4:0]       BranchIdx;
    logic             Done;
    logic [TB_CW-1:0] RetireCount;
    logic             Fault;

    ctrl_sequencer #(
        .IW(9),
        .CW(TB_CW)
`ifdef MEM_TIMEOUT_EN
       ,.MAX_WAIT(TB_MAX_WAIT)
`endif
    ) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .InstrIn(InstrIn),
        .Cond(Cond), .MemReady(MemReady), .IrLoad(IrLoad), .AluOp(AluOp),
        .AluSrcImm(AluSrcImm), .RegAddr(RegAddr), .RegWrEn(RegWrEn),
        .MemToReg(MemToReg), .MemRdEn(MemRdEn), .MemWrEn(MemWrEn),
        .PcEn(PcEn), .PcBranch(PcBranch), .BranchIdx(BranchIdx),
        .Done(Done), .RetireCount(RetireCount), .Fault(Fault)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic             irload;
        logic [3:0]       aluop;
        logic             srcimm;
        logic [2:0]       regaddr;
        logic             regwr;
        logic             memtoreg;
        logic             memrd;
        logic             memwr;
        logic             pcen;
        logic             pcbr;
        logic [4:0]       bidx;
        logic             done;
        logic             fault;
        logic [TB_CW-1:0] retire;
    } obs_t;

    obs_t act;
    assign act = {IrLoad, AluOp, AluSrcImm, RegAddr, RegWrEn, MemToReg, MemRdEn,
                  MemWrEn, PcEn, PcBranch, BranchIdx, Done, Fault, RetireCount};

    // Model: architectural view (last fetched instruction, retired count, fault)
    logic [8:0] m_ir;
    int         m_ret;
    logic       m_fault;

    obs_t  exp_q;
    string exp_lbl;
    bit    exp_valid = 1'b0;
    int    n_checks  = 0;
    int    n_errors  = 0;
    int    mon_rd, mon_pc;

    function automatic obs_t base();
        obs_t e;
        e         = '0;
        e.regaddr = m_ir[4:2];
        e.bidx    = m_ir[4:0];
        e.fault   = m_fault;
        e.retire  = m_ret[TB_CW-1:0];
        return e;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0h want %0h", nm, got, want);
        end
    endtask

    // One clock cycle: inputs applied just after the rising edge, expectation
    // checked on the falling edge by the compare process.
    task automatic cycle(input string lbl, input obs_t e, input logic st,
                         input logic cd, input logic mr, input logic [8:0] ins);
        Start     = st;
        Cond      = cd;
        MemReady  = mr;
        InstrIn   = ins;
        exp_q     = e;
        exp_lbl   = lbl;
        exp_valid = 1'b1;
        #3;
        if (MemRdEn) mon_rd++;
        if (PcEn)    mon_pc++;
        @(posedge Clk);
        #1;
        exp_valid = 1'b0;
        if (e.pcen) m_ret++;
    endtask

    task automatic idle_cycle(input string lbl, input logic st, input logic mr);
        cycle(lbl, base(), st, 1'b1, mr, 9'h1AB);
    endtask

    task automatic halt_cycle(input string lbl, input logic st);
        obs_t e;
        e      = base();
        e.done = 1'b1;
        cycle(lbl, e, st, 1'b0, 1'b1, 9'h155);
    endtask

    task automatic fetch_decode(input string lbl, input logic [8:0] ins, input logic cd);
        obs_t e;
        e        = base();
        e.irload = 1'b1;
        cycle({lbl, "_fetch"}, e, 1'b0, cd, 1'b0, ins);
        m_ir = ins;
        cycle({lbl, "_decode"}, base(), 1'b0, cd, 1'b1, ~ins);
    endtask

    // Fetch, decode, then n MEM cycles with MemReady low (no completion).
    task automatic mem_stall(input string lbl, input logic [8:0] ins, input int n);
        obs_t e;
        fetch_decode(lbl, ins, 1'b0);
        for (int i = 0; i < n; i++) begin
            e       = base();
            e.memrd = (ins[8:5] == 4'hA);
            e.memwr = (ins[8:5] == 4'hB);
            cycle({lbl, "_memwait"}, e, 1'b0, 1'b0, 1'b0, ~ins);
        end
    endtask

    task automatic run_instr(input string lbl, input logic [8:0] ins, input logic cd, input int waits);
        obs_t       e;
        logic [3:0] opc;
        opc = ins[8:5];
        fetch_decode(lbl, ins, cd);
        if (opc <= 4'h9) begin
            e        = base();
            e.aluop  = opc;
            e.srcimm = ins[1];
            e.regwr  = 1'b1;
            e.pcen   = 1'b1;
            cycle({lbl, "_exec"}, e, 1'b0, cd, 1'b1, ~ins);
        end else begin
            case (opc)
                4'hC, 4'hD, 4'hE: begin
                    e      = base();
                    e.pcen = 1'b1;
                    e.pcbr = (opc == 4'hD) || (opc == 4'hC && cd);
                    cycle({lbl, "_exec"}, e, 1'b0, cd, 1'b1, ~ins);
                end
                4'hA, 4'hB: begin
                    for (int i = 0; i <= waits; i++) begin
                        e       = base();
                        e.memrd = (opc == 4'hA);
                        e.memwr = (opc == 4'hB);
                        e.pcen  = (opc == 4'hB) && (i == waits);
                        cycle({lbl, "_mem"}, e, 1'b0, cd, (i == waits), ~ins);
                    end
                    if (opc == 4'hA) begin
                        e          = base();
                        e.regwr    = 1'b1;
                        e.memtoreg = 1'b1;
                        e.pcen     = 1'b1;
                        cycle({lbl, "_wb"}, e, 1'b0, cd, 1'b1, ~ins);
                    end
                end
                default: ;
            endcase
        end
    endtask

    initial begin
        fork
            forever begin
                @(negedge Clk);
                if (exp_valid) begin
                    n_checks++;
                    if (act !== exp_q) begin
                        n_errors++;
                        $display("FAIL %s: got %h want %h", exp_lbl, act, exp_q);
                    end
                end
            end
        join_none

        m_ir = '0; m_ret = 0; m_fault = 1'b0;
        mon_rd = 0; mon_pc = 0;
        Reset = 1'b1; Start = 1'b0; Cond = 1'b0; MemReady = 1'b0; InstrIn = '0;
        #12;
        chk("reset_outputs", 32'(act), 32'd0);
        @(posedge Clk);
        #1;
        Reset = 1'b0;

        idle_cycle("idle", 1'b0, 1'b1);
        idle_cycle("idle_start", 1'b1, 1'b0);

        run_instr("add_r3", 9'b0000_011_00, 1'b0, 0);
        chk("retire_after_add", 32'(RetireCount), 32'd1);
        run_instr("slt_imm_r5", 9'b0111_101_10, 1'b0, 0);
        run_instr("brc_taken", 9'b1100_00101, 1'b1, 0);
        run_instr("brc_not_taken", 9'b1100_00101, 1'b0, 0);
        run_instr("bru", 9'b1101_11111, 1'b0, 0);
        run_instr("nop", 9'b1110_00000, 1'b1, 0);
        run_instr("str_w0", 9'b1011_001_00, 1'b0, 0);
        run_instr("str_w2", 9'b1011_110_00, 1'b0, 2);

        mon_rd = 0; mon_pc = 0;
        run_instr("ldr_w4", 9'b1010_010_00, 1'b0, 4);
        chk("ldr_memrd_cycles", 32'(mon_rd), 32'd5);
        chk("ldr_pcen_pulses", 32'(mon_pc), 32'd1);
        chk("retire_before_hlt", 32'(RetireCount), 32'd9);

        mon_pc = 0;
        fetch_decode("hlt", 9'b1111_00000, 1'b0);
        halt_cycle("halt0", 1'b0);
        halt_cycle("halt1", 1'b0);
        halt_cycle("halt_start", 1'b1);
        chk("hlt_no_pcen", 32'(mon_pc), 32'd0);
        chk("retire_after_hlt", 32'(RetireCount), 32'd9);
        run_instr("sub_after_halt", 9'b0001_010_00, 1'b0, 0);

        for (int i = 0; i < 8; i++) run_instr("nop_wrap", 9'b1110_00000, 1'b0, 0);
        chk("retire_wrap", 32'(RetireCount), 32'd2);

`ifdef MEM_TIMEOUT_EN
        mon_pc = 0;
        mem_stall("str_timeout", 9'b1011_011_00, TB_MAX_WAIT);
        m_fault = 1'b1;
        halt_cycle("timeout_halt0", 1'b0);
        halt_cycle("timeout_halt1", 1'b0);
        chk("timeout_fault", 32'(Fault), 32'd1);
        chk("timeout_no_pcen", 32'(mon_pc), 32'd0);
        halt_cycle("timeout_start", 1'b1);
        m_fault = 1'b0;
        run_instr("nop_after_timeout", 9'b1110_00000, 1'b0, 0);
`else
        begin
            obs_t e;
            mem_stall("str_long", 9'b1011_011_00, 20);
            e       = base();
            e.memwr = 1'b1;
            e.pcen  = 1'b1;
            cycle("str_long_done", e, 1'b0, 1'b0, 1'b1, 9'h0);
        end
`endif

        mem_stall("ldr_reset", 9'b1010_111_00, 2);
        Start = 1'b0; MemReady = 1'b0;
        #2;
        Reset = 1'b1;
        #1;
        chk("reset_mid_mem", 32'(act), 32'd0);
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        m_ir = '0; m_ret = 0; m_fault = 1'b0;
        idle_cycle("idle_after_reset0", 1'b0, 1'b1);
        idle_cycle("idle_after_reset1", 1'b0, 1'b1);
        idle_cycle("idle_after_reset_start", 1'b1, 1'b0);
        run_instr("add_after_reset", 9'b0000_100_10, 1'b0, 0);
        chk("retire_after_reset", 32'(RetireCount), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
